// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, one quotient bit per clock, MSB first.
//
// Parameters:
//   WIDTH        operand/result width in bits (2..64), default 32
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a division (only sampled while busy=0)
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         a division is in progress
//   done         one-cycle pulse, results valid
//   quotient     result quotient (held until the next result)
//   remainder    result remainder (held until the next result)
//   div_by_zero  captured divisor was zero, valid with done
//
// Build option:
//   DIVIDER_SEQ_SIGNED_EN  two's complement operation. Magnitudes are divided and
//                          an extra FIXUP cycle applies the signs (truncating quotient,
//                          remainder follows the dividend's sign).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift/subtract step per cycle, WIDTH cycles
// FIXUP | sign correction of magnitude results (signed build only)
// DONE  | results valid, done=1 for one cycle; start here chains a new operation

module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef DIVIDER_SEQ_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             dbz_q;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_step = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // quo_q starts out holding the dividend; its MSB is shifted into the partial
    // remainder each step while the new quotient bit enters at the LSB. The partial
    // remainder is always below the divisor, so WIDTH+1 bits cover the trial subtract.
    // A zero divisor naturally yields all-ones quotient and remainder=dividend.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], q_bit};

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;

    // The most-negative value's magnitude still fits as an unsigned WIDTH-bit number.
    assign dd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign dv_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
`ifdef DIVIDER_SEQ_SIGNED_EN
                if (last_step) state_d = FIXUP;
`else
                if (last_step) state_d = DONE;
`endif
            end
`ifdef DIVIDER_SEQ_SIGNED_EN
            FIXUP: begin
                busy    = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            dbz_q  <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q <= '0;
            rem_q <= '0;
            dbz_q <= (divisor == '0);
`ifdef DIVIDER_SEQ_SIGNED_EN
            quo_q   <= dd_mag;
            dvsr_q  <= dv_mag;
            neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_q <= dividend[WIDTH-1];
`else
            quo_q  <= dividend;
            dvsr_q <= divisor;
`endif
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

    // Result registers only change on the edge entering DONE, so partial values
    // never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SEQ_SIGNED_EN
        end else if (state_q == FIXUP) begin
            if (dbz_q) begin
                quotient <= '1;
            end else begin
                quotient <= neg_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
            end
            remainder   <= neg_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
            div_by_zero <= dbz_q;
`else
        end else if (last_step) begin
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= dbz_q;
`endif
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq (WIDTH=8) against an arithmetic reference.
// Latency is counted with the accepting edge as edge 1.
module tb_divider_seq;

    localparam int W = 8;
`ifdef DIVIDER_SEQ_SIGNED_EN
    localparam int LAT    = W + 2;
    localparam int BUSY_N = W + 1;
`else
    localparam int LAT    = W + 1;
    localparam int BUSY_N = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIVIDER_SEQ_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
        end
`else
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
`endif
    endfunction

    // Drive a request now; returns 1 time unit after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Wait (bounded) for done and check timing and results. inject_at >= 0 raises
    // start with other operands for one cycle while the operation is running.
    task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           edges;
        int           busy_cnt;
        bit           held;
        model(a, b, eq, er, ez);
        edges    = 1;
        busy_cnt = 0;
        held     = 1'b1;
        for (int k = 0; k < 4 * W && done !== 1'b1; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_z) held = 1'b0;
            start = (k == inject_at);
            if (k == inject_at) begin
                dividend = 8'd9;
                divisor  = 8'd3;
            end
            @(posedge clk);
            edges++;
            #1;
        end
        start = 1'b0;
        chk($sformatf("%s done", tag), done, 1'b1);
        chk($sformatf("%s latency", tag), edges, LAT);
        chk($sformatf("%s busy_cycles", tag), busy_cnt, BUSY_N);
        chk($sformatf("%s busy_in_done", tag), busy, 1'b0);
        chk($sformatf("%s outputs_held", tag), held, 1'b1);
        chk($sformatf("%s quotient", tag), quotient, eq);
        chk($sformatf("%s remainder", tag), remainder, er);
        chk($sformatf("%s div_by_zero", tag), div_by_zero, ez);
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    task automatic drop_check(input string tag);
        @(posedge clk);
        #1;
        chk($sformatf("%s done_falls", tag), done, 1'b0);
        chk($sformatf("%s busy_idle", tag), busy, 1'b0);
        chk($sformatf("%s q_hold", tag), quotient, prev_q);
        chk($sformatf("%s r_hold", tag), remainder, prev_r);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        @(negedge clk);
        launch(a, b);
        finish(a, b, -1, tag);
        drop_check(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s busy", tag), busy, 1'b0);
        chk($sformatf("%s done", tag), done, 1'b0);
        chk($sformatf("%s quotient", tag), quotient, '0);
        chk($sformatf("%s remainder", tag), remainder, '0);
        chk($sformatf("%s div_by_zero", tag), div_by_zero, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        op(8'd100, 8'd7, "100/7");
        op(8'd55, 8'd0, "55/0");
        op(8'd255, 8'd1, "255/1");
        op(8'd0, 8'd255, "0/255");
        op(8'd255, 8'd255, "255/255");
        op(8'd3, 8'd200, "3/200");

        // Ignored mid-run request, then a request in the DONE cycle chains directly.
        @(negedge clk);
        launch(8'd200, 8'd10);
        finish(8'd200, 8'd10, 3, "ignore_midrun");
        launch(8'd250, 8'd3);
        chk("chain single_done", done, 1'b0);
        chk("chain busy_no_gap", busy, 1'b1);
        finish(8'd250, 8'd3, -1, "chain");
        drop_check("chain");

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        launch(8'd250, 8'd3);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort_now");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("abort_hold");
        @(negedge clk);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        op(8'd250, 8'd3, "after_abort");

`ifdef DIVIDER_SEQ_SIGNED_EN
        op(8'hF9, 8'd2, "-7/2");
        op(8'h80, 8'hFF, "-128/-1");
        op(8'd5, 8'd0, "5/0");
        op(8'h80, 8'd0, "-128/0");
        op(8'd7, 8'hFE, "7/-2");
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when busy=0.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: numerator, captured on the accepting edge.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: denominator, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the captured divisor was zero; valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, plus FIXUP only when signed mode is enabled.
REQ-013 In IDLE or DONE, start=1 SHALL capture both operands, clear the iteration counter and enter RUN on that edge, with busy=1 from the next cycle.
REQ-014 In RUN, busy=1 SHALL hold, start and operand inputs SHALL be ignored, and exactly one restoring shift/subtract step SHALL be performed per cycle, MSB first.
REQ-015 After exactly WIDTH RUN cycles the FSM SHALL enter DONE (unsigned build) with busy=0, done=1 and quotient/remainder/div_by_zero valid.
REQ-016 DONE SHALL last one cycle; done SHALL then fall and the FSM SHALL return to IDLE unless start=1 (REQ-013).
REQ-017 Outputs SHALL hold their last results until the next DONE state or reset; intermediate values SHALL never appear on quotient or remainder.
REQ-018 Unsigned latency SHALL be WIDTH+1 edges from the accepting edge to the edge after which done=1 is first seen.
REQ-019 For divisor=0 the block SHALL produce quotient all ones and remainder=dividend, set div_by_zero=1, and keep the same latency.
REQ-020 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap during an operation.

Reset
REQ-021 While rst_n=0, state SHALL be IDLE and busy, done, quotient, remainder and div_by_zero SHALL all be 0, regardless of clk.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL start a fresh operation.

Configuration
REQ-023 With DIVIDER_SEQ_SIGNED_EN defined, operands and results SHALL be two's complement, the quotient SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-024 With DIVIDER_SEQ_SIGNED_EN defined, operand magnitudes SHALL be taken at capture.
REQ-025 With DIVIDER_SEQ_SIGNED_EN defined, after RUN the FSM SHALL spend one FIXUP cycle (busy=1) applying signs, so latency is WIDTH+2.
REQ-026 With DIVIDER_SEQ_SIGNED_EN defined, division by zero SHALL give quotient=-1 and remainder=dividend, with div_by_zero=1.
REQ-027 With DIVIDER_SEQ_SIGNED_EN defined, most-negative/-1 SHALL give quotient=most-negative and remainder=0, with div_by_zero=0.
REQ-028 Without DIVIDER_SEQ_SIGNED_EN, the block SHALL be unsigned only, with no FIXUP state and no sign logic.

Verification (WIDTH=8)
REQ-029 Unsigned: 100/7 -> done seen exactly 9 edges after the accepting edge, quotient=14, remainder=2, div_by_zero=0, busy=1 for 8 cycles.
REQ-030 Unsigned: 55/0 -> quotient=0xFF, remainder=55, div_by_zero=1, same latency.
REQ-031 Start with 9/3 mid-RUN of 200/10 -> result 20 r 0, one done pulse, second request ignored; start asserted in the DONE cycle is accepted -> next result with no idle gap.
REQ-032 rst_n low at RUN cycle 4 of 250/3 -> all outputs 0 immediately, no done; a following 250/3 -> 83 r 1.
REQ-033 Signed build: -7/2 -> quotient=0xFD, remainder=0xFF, latency 10.
REQ-034 Signed build: -128/-1 -> quotient=0x80, remainder=0; 5/0 -> quotient=0xFF, remainder=5, div_by_zero=1.
